y86_bus_tracer: RTL and testbench

- Passive downstream observer of the y86_seq memory bus. Samples every read/write transaction and the current opcode, and packs each one into a trace record.
- Buffers records in a DEPTH-entry FIFO that drains over a valid/ready stream to a debug host or testbench scoreboard.
- Keeps read, write, collision and drop statistics. Never drives the CPU bus.

---
 rtl/y86_trace_pkg.sv | 13 +
 rtl/y86_trace_fifo.sv | 43 ++++
 rtl/y86_bus_tracer.sv | 69 ++++++
 tb/tb_y86_bus_tracer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/y86_trace_pkg.sv
// y86_trace_pkg: trace record layout and kind encodings for the y86 bus tracer
package y86_trace_pkg;
  localparam int TRACE_W = 74;
  localparam logic [1:0] KIND_RD   = 2'b01;
  localparam logic [1:0] KIND_WR   = 2'b10;
  localparam logic [1:0] KIND_COLL = 2'b11;
  typedef struct packed {
    logic [1:0]  kind;
    logic [7:0]  opcode;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_rec_t;
endpackage

// File: rtl/y86_trace_fifo.sv
// y86_trace_fifo: generic synchronous FIFO; a full FIFO still accepts a push when popped in the same edge
module y86_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 74,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic do_push, do_pop;
  always_comb begin
    empty_o = level_q == '0;
    full_o = level_q == LW'(DEPTH);
    do_pop = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    level_d = level_q + LW'(do_push) - LW'(do_pop);
    dout_o = empty_o ? '0 : mem[rd_ptr_q];
    level_o = level_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_q + AW'(do_pop);
      wr_ptr_q <= wr_ptr_q + AW'(do_push);
      level_q <= level_d;
    end
  end
  always_ff @(posedge clk) if (do_push) mem[wr_ptr_q] <= din_i;
endmodule

// File: rtl/y86_bus_tracer.sv
// y86_bus_tracer: passive y86 memory-bus observer packing transactions into a drained trace FIFO
module y86_bus_tracer
  import y86_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              bus_A,
  input  logic [31:0]              bus_in,
  input  logic [31:0]              bus_out,
  input  logic                     bus_RE,
  input  logic                     bus_WE,
  input  logic [7:0]               current_opcode,
  input  logic                     trace_en,
  input  logic                     clr_stats,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [TRACE_W-1:0]       trace_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         rd_count,
  output logic [CNT_W-1:0]         wr_count,
  output logic [15:0]              drop_count,
  output logic                     overflow
);
  trace_rec_t rec;
  logic cap, pop, push, drop, full, empty;
  logic [CNT_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [15:0] drop_q, drop_d;
  logic ovf_q, ovf_d;
  always_comb begin
    cap = trace_en && (bus_RE || bus_WE);
    pop = trace_valid && trace_ready;
    push = cap && (!full || pop);
    drop = cap && full && !pop;
    rec.kind = bus_WE ? (bus_RE ? KIND_COLL : KIND_WR) : KIND_RD;
    rec.opcode = current_opcode;
    rec.addr = bus_A;
    rec.data = bus_WE ? bus_out : bus_in;
    rd_d = (clr_stats ? '0 : rd_q) + CNT_W'(cap && bus_RE);
    wr_d = (clr_stats ? '0 : wr_q) + CNT_W'(cap && bus_WE);
    drop_d = clr_stats ? '0 : drop_q;
    drop_d = drop_d + 16'(drop && drop_d != '1);
    ovf_d = (!clr_stats && ovf_q) || drop;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      drop_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      drop_q <= drop_d;
      ovf_q <= ovf_d;
    end
  end
  y86_trace_fifo #(.DEPTH(DEPTH), .W(TRACE_W)) u_fifo (
    .clk(clk), .rst(rst), .push_i(push), .din_i(rec), .pop_i(trace_ready),
    .dout_o(trace_data), .full_o(full), .empty_o(empty), .level_o(fifo_level)
  );
  assign trace_valid = !empty;
  assign rd_count = rd_q;
  assign wr_count = wr_q;
  assign drop_count = drop_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_y86_bus_tracer.sv
// tb_y86_bus_tracer: directed table, corner sequences and random traffic against a queue-based model
module tb_y86_bus_tracer;
  localparam int DEPTH = 16;
  logic clk = 0, rst = 1;
  logic [31:0] bus_A = 0, bus_in = 0, bus_out = 0;
  logic bus_RE = 0, bus_WE = 0, trace_en = 1, clr_stats = 0, trace_ready = 0;
  logic [7:0] current_opcode = 0;
  logic trace_valid, overflow;
  logic [73:0] trace_data;
  logic [4:0] fifo_level;
  logic [31:0] rd_count, wr_count;
  logic [15:0] drop_count;
  int vectors = 0, miscompares = 0;
  logic [73:0] mq[$];
  logic [31:0] m_rd, m_wr;
  logic [15:0] m_drop;
  logic m_ovf;

  y86_bus_tracer #(.DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus_A(bus_A), .bus_in(bus_in), .bus_out(bus_out),
    .bus_RE(bus_RE), .bus_WE(bus_WE), .current_opcode(current_opcode),
    .trace_en(trace_en), .clr_stats(clr_stats), .trace_valid(trace_valid),
    .trace_ready(trace_ready), .trace_data(trace_data), .fifo_level(fifo_level),
    .rd_count(rd_count), .wr_count(wr_count), .drop_count(drop_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [73:0] act, input logic [73:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Model: a queue of records plus counters, advanced once per clock edge from the sampled inputs
  task automatic model_edge();
    logic cap;
    if (rst) begin
      mq.delete();
      m_rd = 0; m_wr = 0; m_drop = 0; m_ovf = 0;
      return;
    end
    cap = trace_en && (bus_RE || bus_WE);
    if (clr_stats) begin
      m_rd = 0; m_wr = 0; m_drop = 0; m_ovf = 0;
    end
    if (cap) begin
      m_rd += 32'(bus_RE);
      m_wr += 32'(bus_WE);
    end
    if (mq.size() > 0 && trace_ready) void'(mq.pop_front());
    if (cap) begin
      if (mq.size() < DEPTH)
        mq.push_back({bus_RE && !bus_WE ? 2'b01 : (bus_WE && !bus_RE ? 2'b10 : 2'b11),
                      current_opcode, bus_A, bus_WE ? bus_out : bus_in});
      else begin
        if (m_drop != 16'hFFFF) m_drop++;
        m_ovf = 1;
      end
    end
  endtask

  task automatic compare_all();
    chk("valid", 74'(trace_valid), 74'(mq.size() != 0));
    chk("data", trace_data, mq.size() != 0 ? mq[0] : 74'(0));
    chk("level", 74'(fifo_level), 74'(mq.size()));
    chk("rd_count", 74'(rd_count), 74'(m_rd));
    chk("wr_count", 74'(wr_count), 74'(m_wr));
    chk("drop_count", 74'(drop_count), 74'(m_drop));
    chk("overflow", 74'(overflow), 74'(m_ovf));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input logic re, input logic we, input logic [31:0] a,
                       input logic [31:0] din, input logic [31:0] dout, input logic [7:0] op);
    bus_RE = re; bus_WE = we; bus_A = a; bus_in = din; bus_out = dout; current_opcode = op;
  endtask

  typedef struct {
    logic re, we;
    logic [31:0] a, din, dout;
    logic [7:0] op;
    logic [1:0] e_kind;
    logic [31:0] e_data, e_rd, e_wr;
  } vec_t;
  vec_t tbl[4];

  initial begin
    tbl[0] = '{1, 0, 32'h0,   32'h0000C301, 32'h0,        8'h89, 2'b01, 32'h0000C301, 1, 0};
    tbl[1] = '{0, 1, 32'h104, 32'h0,        32'hDEADBEEF, 8'h40, 2'b10, 32'hDEADBEEF, 1, 1};
    tbl[2] = '{1, 1, 32'h200, 32'h1111,     32'h2222,     8'hA0, 2'b11, 32'h2222,     2, 2};
    tbl[3] = '{1, 0, 32'h8,   32'h55,       32'h77,       8'h30, 2'b01, 32'h55,       3, 2};
    rst = 1;
    step();
    chk("reset_valid", 74'(trace_valid), 0);
    chk("reset_data", trace_data, 0);
    rst = 0;
    trace_ready = 1;
    for (int i = 0; i < 4; i++) begin
      drive(tbl[i].re, tbl[i].we, tbl[i].a, tbl[i].din, tbl[i].dout, tbl[i].op);
      step();
      chk("tbl_valid", 74'(trace_valid), 1);
      chk("tbl_kind", 74'(trace_data[73:72]), 74'(tbl[i].e_kind));
      chk("tbl_op", 74'(trace_data[71:64]), 74'(tbl[i].op));
      chk("tbl_addr", 74'(trace_data[63:32]), 74'(tbl[i].a));
      chk("tbl_data", 74'(trace_data[31:0]), 74'(tbl[i].e_data));
      chk("tbl_rd", 74'(rd_count), 74'(tbl[i].e_rd));
      chk("tbl_wr", 74'(wr_count), 74'(tbl[i].e_wr));
    end
    drive(0, 0, 0, 0, 0, 0);
    step();
    trace_ready = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 32'(i), 32'(i), 0, 8'h50);
      step();
    end
    chk("fill_level", 74'(fifo_level), 16);
    chk("fill_drop", 74'(drop_count), 4);
    chk("fill_ovf", 74'(overflow), 1);
    chk("fill_head", 74'(trace_data[63:32]), 0);
    trace_ready = 1;
    drive(1, 0, 32'h999, 32'h999, 0, 8'h51);
    step();
    chk("fullpp_level", 74'(fifo_level), 16);
    chk("fullpp_drop", 74'(drop_count), 4);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      chk("drain_addr", 74'(trace_data[63:32]), i == 16 ? 74'h999 : 74'(i));
      step();
    end
    chk("drained_valid", 74'(trace_valid), 0);
    drive(1, 1, 32'h300, 32'h1, 32'hCAFE0001, 8'h61);
    step();
    chk("coll_kind", 74'(trace_data[73:72]), 74'(2'b11));
    chk("coll_data", 74'(trace_data[31:0]), 74'h0CAFE0001);
    drive(1, 0, 32'h304, 32'h5, 0, 8'h62);
    clr_stats = 1;
    step();
    clr_stats = 0;
    chk("clr_rd", 74'(rd_count), 1);
    chk("clr_wr", 74'(wr_count), 0);
    chk("clr_ovf", 74'(overflow), 0);
    chk("clr_drop", 74'(drop_count), 0);
    drive(0, 0, 0, 0, 0, 0);
    step();
    trace_ready = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 32'h400 + 32'(i), 32'(i), 0, 8'h70);
      step();
    end
    chk("pre_rst_level", 74'(fifo_level), 5);
    chk("pre_rst_valid", 74'(trace_valid), 1);
    rst = 1;
    step();
    chk("rst_valid", 74'(trace_valid), 0);
    chk("rst_level", 74'(fifo_level), 0);
    chk("rst_rd", 74'(rd_count), 0);
    rst = 0;
    drive(1, 0, 32'h500, 32'hAB, 0, 8'h71);
    step();
    chk("post_rst_valid", 74'(trace_valid), 1);
    chk("post_rst_addr", 74'(trace_data[63:32]), 74'h500);
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, 8'($urandom));
      trace_en = $urandom_range(0, 99) < 85;
      trace_ready = $urandom_range(0, 99) < ((i % 400) < 200 ? 20 : 80);
      clr_stats = $urandom_range(0, 99) < 3;
      rst = $urandom_range(0, 999) < 5;
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
